// File: rtl/step_clock_pkg.sv
// Shared definitions for the step clock front-end: FSM encoding and run-rate helper.
package step_clock_pkg;

    typedef enum logic [1:0] {
        STEP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } step_state_t;

    // log2 of the free-run period in clock cycles for a given rate select.
    function automatic int period_shift(input int run_div_w, input logic [1:0] rate_sel);
        return run_div_w - 2 * int'(rate_sel);
    endfunction

endpackage

// File: rtl/step_clock_gen_if.sv
// Button, switch and datapath-control signals of the step clock front-end.
interface step_clock_gen_if #(
    parameter int STEP_CNT_W = 16
) ();

    logic                  btn_step_n;
    logic                  btn_rst_n;
    logic                  run_mode;
    logic [1:0]            rate_sel;
    logic                  step_en;
    logic                  dp_reset;
    logic [STEP_CNT_W-1:0] step_count;
    logic [1:0]            state;

    modport master (
        output btn_step_n, btn_rst_n, run_mode, rate_sel,
        input  step_en, dp_reset, step_count, state
    );

    modport slave (
        input  btn_step_n, btn_rst_n, run_mode, rate_sel,
        output step_en, dp_reset, step_count, state
    );

endinterface

// File: rtl/debounce_sync.sv
// Synchronizes one active-low button, debounces it and emits a one-cycle press event.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // press registers on the same edge the level falls
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/step_clock_gen.sv
// Turns bouncy DE0 buttons into a clean datapath step enable and reset, with free-run mode.
//   state | meaning
//   STEP  | one step_en per debounced step-button press
//   RUN   | step_en every 2^(RUN_DIV_W - 2*rate_sel) cycles
//   HOLD  | reset button held: datapath in reset, counters cleared
module step_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV_W       = 26,
    parameter int STEP_CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    step_clock_gen_if.slave  bus
);
    import step_clock_pkg::*;

    step_state_t             state_q, state_d;
    logic                    step_en_q, step_en_d;
    logic                    dp_reset_q, dp_reset_d;
    logic [RUN_DIV_W-1:0]    div_q, div_d;
    logic [RUN_DIV_W-1:0]    div_last;
    logic [STEP_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]              rate_q;
    int                      shift;

    logic step_level, step_press;
    logic rst_level, rst_press;
    logic unused_dbnc;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_step (
        .clock (clock),
        .reset (reset),
        .btn_n (bus.btn_step_n),
        .level (step_level),
        .press (step_press)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_rst (
        .clock (clock),
        .reset (reset),
        .btn_n (bus.btn_rst_n),
        .level (rst_level),
        .press (rst_press)
    );

    assign unused_dbnc = step_level ^ rst_press;

    // Terminal count is the low 'shift' bits set, so no wider-than-divider constant is needed.
    always_comb begin
        shift = period_shift(RUN_DIV_W, bus.rate_sel);
        for (int i = 0; i < RUN_DIV_W; i++) begin
            div_last[i] = (i < shift);
        end
    end

    always_comb begin
        state_d    = state_q;
        step_en_d  = 1'b0;
        dp_reset_d = 1'b0;
        div_d      = div_q;
        cnt_d      = cnt_q;
        if (!rst_level) begin
            state_d    = HOLD;
            dp_reset_d = 1'b1;
            div_d      = '0;
        end else begin
            case (state_q)
                STEP: begin
                    div_d = '0;
                    if (bus.run_mode) begin
                        state_d = RUN;
                    end else if (step_press) begin
                        step_en_d = 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.run_mode) begin
                        state_d = STEP;
                        div_d   = '0;
                    end else if (bus.rate_sel != rate_q) begin
                        div_d = '0;
                    end else if (div_q == div_last) begin
                        step_en_d = 1'b1;
                        div_d     = '0;
                    end else begin
                        div_d = div_q + RUN_DIV_W'(1);
                    end
                end
                HOLD: begin
                    div_d = '0;
                    if (bus.run_mode) begin
                        state_d = RUN;
                    end else begin
                        state_d = STEP;
                    end
                end
                default: begin
                    state_d = STEP;
                    div_d   = '0;
                end
            endcase
        end
        if (!rst_level) begin
            cnt_d = '0;
        end else if (step_en_d) begin
            cnt_d = cnt_q + STEP_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= STEP;
            step_en_q  <= 1'b0;
            dp_reset_q <= 1'b1;
            div_q      <= '0;
            cnt_q      <= '0;
            rate_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            step_en_q  <= step_en_d;
            dp_reset_q <= dp_reset_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            rate_q     <= bus.rate_sel;
        end
    end

    assign bus.step_en    = step_en_q;
    assign bus.dp_reset   = dp_reset_q;
    assign bus.step_count = cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Directed bench for step_clock_gen with DEBOUNCE_CYCLES=4, RUN_DIV_W=6, STEP_CNT_W=4.
module tb_step_clock_gen;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses, first, last;

    step_clock_gen_if #(.STEP_CNT_W(4)) bus ();

    step_clock_gen #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV_W       (6),
        .STEP_CNT_W      (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advances n edges, counting step_en pulses and the edge index (1-based) of first/last.
    task automatic run_cycles(input int n, output int p, output int f, output int l);
        p = 0;
        f = -1;
        l = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.step_en === 1'b1) begin
                p++;
                if (f < 0) f = k;
                l = k;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset          = 1'b0;
        bus.btn_step_n = 1'b1;
        bus.btn_rst_n  = 1'b1;
        bus.run_mode   = 1'b0;
        bus.rate_sel   = 2'd0;

        // 1: reset values, then dp_reset drops on the first edge after release
        tick(); tick(); tick();
        check("rst_step_en", 32'(bus.step_en), 0);
        check("rst_dp_reset", 32'(bus.dp_reset), 1);
        check("rst_count", 32'(bus.step_count), 0);
        check("rst_state", 32'(bus.state), 0);
        reset = 1'b1;
        tick();
        check("rel_dp_reset", 32'(bus.dp_reset), 0);
        check("rel_state", 32'(bus.state), 0);

        // 2: clean press held 12 cycles -> one pulse at edge 7
        bus.btn_step_n = 1'b0;
        run_cycles(12, pulses, first, last);
        check("press_pulses", 32'(pulses), 1);
        check("press_latency", 32'(first), 7);
        check("press_count", 32'(bus.step_count), 1);
        bus.btn_step_n = 1'b1;
        run_cycles(12, pulses, first, last);
        check("release_pulses", 32'(pulses), 0);
        check("release_count", 32'(bus.step_count), 1);

        // 3: 3-cycle glitch is filtered
        do_reset();
        bus.btn_step_n = 1'b0;
        run_cycles(3, pulses, first, last);
        check("glitch_pulses_a", 32'(pulses), 0);
        bus.btn_step_n = 1'b1;
        run_cycles(12, pulses, first, last);
        check("glitch_pulses_b", 32'(pulses), 0);
        check("glitch_count", 32'(bus.step_count), 0);

        // 4: free-run, period 64 then period 4, counter wraps at 16
        do_reset();
        bus.run_mode = 1'b1;
        tick();
        check("run_state", 32'(bus.state), 1);
        run_cycles(64, pulses, first, last);
        check("run64_pulses_a", 32'(pulses), 1);
        check("run64_first_a", 32'(first), 64);
        run_cycles(64, pulses, first, last);
        check("run64_pulses_b", 32'(pulses), 1);
        check("run64_first_b", 32'(first), 64);
        check("run64_count", 32'(bus.step_count), 2);
        bus.rate_sel = 2'd2;
        run_cycles(57, pulses, first, last);
        check("run4_pulses", 32'(pulses), 14);
        check("run4_first", 32'(first), 5);
        check("run4_last", 32'(last), 57);
        check("run4_wrap_count", 32'(bus.step_count), 0);

        // 5: reset button in RUN -> HOLD, then back to RUN with a fresh period
        bus.btn_rst_n = 1'b0;
        run_cycles(6, pulses, first, last);
        check("hold_pre_state", 32'(bus.state), 1);
        check("hold_pre_dp_reset", 32'(bus.dp_reset), 0);
        tick();
        check("hold_state", 32'(bus.state), 2);
        check("hold_dp_reset", 32'(bus.dp_reset), 1);
        check("hold_step_en", 32'(bus.step_en), 0);
        check("hold_count", 32'(bus.step_count), 0);
        run_cycles(13, pulses, first, last);
        check("hold_pulses", 32'(pulses), 0);
        check("hold_state_b", 32'(bus.state), 2);
        bus.btn_rst_n = 1'b1;
        run_cycles(6, pulses, first, last);
        check("unhold_pre_state", 32'(bus.state), 2);
        check("unhold_pre_pulses", 32'(pulses), 0);
        tick();
        check("unhold_state", 32'(bus.state), 1);
        check("unhold_dp_reset", 32'(bus.dp_reset), 0);
        run_cycles(4, pulses, first, last);
        check("unhold_pulses", 32'(pulses), 1);
        check("unhold_first", 32'(first), 4);
        check("unhold_count", 32'(bus.step_count), 1);

        // 6: both buttons together in STEP -> reset wins, no step
        bus.run_mode = 1'b0;
        bus.rate_sel = 2'd0;
        do_reset();
        bus.btn_step_n = 1'b0;
        bus.btn_rst_n  = 1'b0;
        run_cycles(6, pulses, first, last);
        check("both_pre_pulses", 32'(pulses), 0);
        check("both_pre_state", 32'(bus.state), 0);
        tick();
        check("both_state", 32'(bus.state), 2);
        check("both_dp_reset", 32'(bus.dp_reset), 1);
        check("both_step_en", 32'(bus.step_en), 0);
        run_cycles(13, pulses, first, last);
        check("both_hold_pulses", 32'(pulses), 0);
        bus.btn_step_n = 1'b1;
        bus.btn_rst_n  = 1'b1;
        run_cycles(20, pulses, first, last);
        check("both_rel_pulses", 32'(pulses), 0);
        check("both_rel_state", 32'(bus.state), 0);
        check("both_rel_dp_reset", 32'(bus.dp_reset), 0);
        check("both_rel_count", 32'(bus.step_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
